// File: rtl/phase_b.sv
// Final modular correction: subtract m limb-serially until a < m.
// Gives up after MAX_SUB subtractions and flags err.
module phase_b #(
  parameter int WIDTH   = 3072,
  parameter int LIMB    = 64,
  parameter int MAX_SUB = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] r,
  output logic             en_out,
  output logic             err,
  output logic             busy
);

  localparam int NL = WIDTH / LIMB;
  localparam int KW = (NL > 1) ? $clog2(NL) : 1;
  localparam int SW = (MAX_SUB > 0) ? $clog2(MAX_SUB + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    CHECK
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] d_reg;
  logic [KW-1:0]    k;
  logic [SW-1:0]    subs;
  logic             borrow;
  logic [LIMB:0]    diff;

  // Low limb difference; the extra top bit is the outgoing borrow.
  always_comb begin
    diff = {1'b0, a_reg[LIMB-1:0]}
         - {1'b0, m_reg[LIMB-1:0]}
         - {{LIMB{1'b0}}, borrow};
  end

  assign busy = (state != IDLE);

  // Control FSM with the limb datapath and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      m_reg  <= '0;
      d_reg  <= '0;
      k      <= '0;
      subs   <= '0;
      borrow <= 1'b0;
      r      <= '0;
      en_out <= 1'b0;
      err    <= 1'b0;
    end else begin
      en_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en_in) begin
            a_reg  <= a_in;
            m_reg  <= m;
            k      <= '0;
            subs   <= '0;
            borrow <= 1'b0;
            state  <= SUB;
          end
        end
        SUB: begin
          borrow <= diff[LIMB];
          a_reg  <= {a_reg[LIMB-1:0], a_reg[WIDTH-1:LIMB]};
          m_reg  <= {m_reg[LIMB-1:0], m_reg[WIDTH-1:LIMB]};
          d_reg  <= {diff[LIMB-1:0], d_reg[WIDTH-1:LIMB]};
          if (k == KW'(NL - 1)) begin
            k     <= '0;
            state <= CHECK;
          end else begin
            k <= k + 1'b1;
          end
        end
        CHECK: begin
          if (borrow) begin
            r      <= a_reg;
            err    <= 1'b0;
            en_out <= 1'b1;
            state  <= IDLE;
          end else if (subs < SW'(MAX_SUB)) begin
            a_reg  <= d_reg;
            subs   <= subs + 1'b1;
            borrow <= 1'b0;
            k      <= '0;
            state  <= SUB;
          end else begin
            r      <= a_reg;
            err    <= 1'b1;
            en_out <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_b.sv
// Bench for phase_b: directed cases on a 16/4 instance,
// random cases on 16/4 and full 3072/64 against a mod model.
module tb_phase_b;

  localparam int FW  = 3072;
  localparam int FL  = 64;
  localparam int FNL = FW / FL;
  localparam int SW  = 16;
  localparam int SL  = 4;
  localparam int SNL = SW / SL;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          s_en_in = 1'b0;
  logic [SW-1:0] s_a = '0;
  logic [SW-1:0] s_m = '0;
  logic [SW-1:0] s_r;
  logic          s_en_out, s_err, s_busy;

  logic          f_en_in = 1'b0;
  logic [FW-1:0] f_a = '0;
  logic [FW-1:0] f_m = '0;
  logic [FW-1:0] f_r;
  logic          f_en_out, f_err, f_busy;

  phase_b #(.WIDTH(SW), .LIMB(SL), .MAX_SUB(2)) u_s (
    .clk(clk), .rst(rst), .en_in(s_en_in),
    .a_in(s_a), .m(s_m), .r(s_r),
    .en_out(s_en_out), .err(s_err), .busy(s_busy)
  );

  phase_b #(.WIDTH(FW), .LIMB(FL), .MAX_SUB(2)) u_f (
    .clk(clk), .rst(rst), .en_in(f_en_in),
    .a_in(f_a), .m(f_m), .r(f_r),
    .en_out(f_en_out), .err(f_err), .busy(f_busy)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [FW-1:0] got,
                       input logic [FW-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ..%h expected ..%h",
               tag, got[127:0], exp[127:0]);
    end
  endtask

  // Called just after a rising edge; leaves just after the accept edge.
  task automatic start_op(input bit sel,
                          input logic [FW-1:0] a,
                          input logic [FW-1:0] mm);
    if (sel) begin
      f_a = a; f_m = mm; f_en_in = 1'b1;
    end else begin
      s_a = a[SW-1:0]; s_m = mm[SW-1:0]; s_en_in = 1'b1;
    end
    @(posedge clk); #1;
    f_en_in = 1'b0;
    s_en_in = 1'b0;
  endtask

  // Counts edges since accept until en_out; -1 if it never comes.
  task automatic wait_done(input bit sel, input int start,
                           output int lat);
    bit seen;
    seen = 1'b0;
    lat  = start;
    while (!seen && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      seen = sel ? f_en_out : s_en_out;
    end
    if (!seen) lat = -1;
  endtask

  task automatic run_op(input bit sel, input string tag,
                        input logic [FW-1:0] a,
                        input logic [FW-1:0] mm,
                        input logic [FW-1:0] exp_r,
                        input bit exp_err,
                        input int exp_lat);
    int lat;
    logic [FW-1:0] got;
    start_op(sel, a, mm);
    check({tag, "/busy"}, FW'(sel ? f_busy : s_busy), FW'(1));
    wait_done(sel, 0, lat);
    check({tag, "/lat"}, FW'(lat), FW'(exp_lat));
    got = sel ? f_r : FW'(s_r);
    check({tag, "/r"}, got, exp_r);
    check({tag, "/err"}, FW'(sel ? f_err : s_err), FW'(exp_err));
    @(posedge clk); #1;
    check({tag, "/pulse"}, FW'(sel ? f_en_out : s_en_out), FW'(0));
  endtask

  // Reference: reduce by repeated subtraction, at most two times.
  task automatic model(input logic [FW-1:0] a,
                       input logic [FW-1:0] mm,
                       output logic [FW-1:0] rr,
                       output bit e,
                       output int passes);
    if (mm == '0 || (a / mm) > 2) begin
      e = 1'b1; rr = a - 2 * mm; passes = 3;
    end else begin
      e = 1'b0; rr = a % mm; passes = int'(a / mm) + 1;
    end
  endtask

  function automatic logic [FW-1:0] rnd_wide();
    logic [FW-1:0] v;
    for (int i = 0; i < FW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  logic [FW-1:0] ra, rm, er, rem;
  bit            ee;
  int            ps, lat, pulses;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst/r", FW'(s_r), FW'(0));
    check("rst/en_out", FW'(s_en_out), FW'(0));
    check("rst/err", FW'(s_err), FW'(0));
    check("rst/busy", FW'(s_busy), FW'(0));
    check("rst/f_r", f_r, FW'(0));
    check("rst/f_busy", FW'(f_busy), FW'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, "T1", FW'(16'h0005), FW'(16'h0007), FW'(16'h0005), 0, 5);
    run_op(0, "T2", FW'(16'h000E), FW'(16'h0007), FW'(16'h0000), 0, 15);
    run_op(0, "T3", FW'(16'h1000), FW'(16'h0FFF), FW'(16'h0001), 0, 10);
    run_op(0, "T4", FW'(16'hFFFF), FW'(16'h5000), FW'(16'h5FFF), 1, 15);

    start_op(0, FW'(16'h000E), FW'(16'h0007));
    @(posedge clk); #1;
    s_a = 16'h0005; s_m = 16'h0007; s_en_in = 1'b1;
    @(posedge clk); #1;
    s_en_in = 1'b0;
    wait_done(0, 2, lat);
    check("T5/lat", FW'(lat), FW'(15));
    check("T5/r", FW'(s_r), FW'(0));
    start_op(0, FW'(16'h1000), FW'(16'h0FFF));
    wait_done(0, 0, lat);
    check("T5b/lat", FW'(lat), FW'(10));
    check("T5b/r", FW'(s_r), FW'(1));
    check("T5b/err", FW'(s_err), FW'(0));
    @(posedge clk); #1;

    start_op(0, FW'(16'hFFFF), FW'(16'h5000));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("T6/busy", FW'(s_busy), FW'(0));
    check("T6/r", FW'(s_r), FW'(0));
    check("T6/err", FW'(s_err), FW'(0));
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      pulses += int'(s_en_out);
    end
    check("T6/no_en_out", FW'(pulses), FW'(0));
    run_op(0, "T6/T1", FW'(16'h0005), FW'(16'h0007), FW'(16'h0005), 0, 5);

    for (int i = 0; i < 60; i++) begin
      ra = FW'($urandom_range(0, 65535));
      if ($urandom_range(0, 9) == 0) rm = '0;
      else rm = FW'($urandom_range(1, 65535) >> $urandom_range(0, 15));
      model(ra, rm, er, ee, ps);
      run_op(0, $sformatf("s_rnd%0d", i), ra, rm, er, ee, ps * (SNL + 1));
    end

    for (int i = 0; i < 150; i++) begin
      rm = rnd_wide() >> $urandom_range(2, FW - 1);
      if (rm == '0) rm = FW'(1);
      rem = rnd_wide() % rm;
      ra = FW'($urandom_range(0, 2)) * rm + rem;
      er = ra % rm;
      ps = int'(ra / rm) + 1;
      run_op(1, $sformatf("f_rnd%0d", i), ra, rm, er, 0, ps * (FNL + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
